seq_shifter: RTL



---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_step.sv | 25 ++
 rtl/seq_shifter.sv | 111 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shift unit.
// Holds the 2-bit shift-op encoding and the control FSM state encoding.
package shifter_pkg;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step.
// Ports: data_i operand, op_i shift op, rot_i rotate select, next_o stepped data.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] next_o
);

    // Fill bit depends on op: wrap-around for rotates, sign for ASR, else zero.
    always_comb begin
        next_o = data_i;
        unique case (op_i)
            SH_LSL:  next_o = {data_i[WIDTH-2:0], rot_i & data_i[WIDTH-1]};
            SH_LSR:  next_o = {rot_i & data_i[0], data_i[WIDTH-1:1]};
            SH_ASR:  next_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default: next_o = data_i;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Ports: clk, reset, in_valid/in_ready/in/shift/rotate/shift_amt request,
//        out_valid/out_ready/sout result, busy while SHIFT or DONE.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic             rotate,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic             rot_q, rot_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step_data;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .rot_i  (rot_q),
        .next_o (step_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Pass or zero amount needs no steps.
                    if (shift == SH_PASS || shift_amt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    always_comb begin
        data_d = data_q;
        op_d   = op_q;
        rot_d  = rot_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE && in_valid) begin
            data_d = in;
            op_d   = shift;
            rot_d  = rotate;
            cnt_d  = shift_amt;
        end else if (state_q == SHIFT) begin
            data_d = step_data;
            cnt_d  = cnt_q - AMT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            op_q   <= SH_PASS;
            rot_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            op_q   <= op_d;
            rot_q  <= rot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sout = data_q;

endmodule
